// File: rtl/rf_pkg.sv
// Shared constants and elaboration helpers for the parametrised register file.
package rf_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;

    // The top register index has no storage; reads of it return the fetch unit's PC.
    function automatic int pc_index(input int num_regs);
        return num_regs - 1;
    endfunction

    function automatic bit valid_num_regs(input int num_regs);
        return (num_regs >= 4) && ((num_regs & (num_regs - 1)) == 0);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: PC alias select, write bypass priority chain, stored-value mux.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [(NUM_REGS-1)*DATA_W-1:0]   store_flat,
    input  logic [NUM_REGS-2:0]              sb,
    input  logic                             le0,
    input  logic [ADDR_W-1:0]                rw0,
    input  logic [DATA_W-1:0]                pw0,
    input  logic                             le1,
    input  logic [ADDR_W-1:0]                rw1,
    input  logic [DATA_W-1:0]                pw1,
    input  logic [DATA_W-1:0]                pc,
    output logic [DATA_W-1:0]                data,
    output logic                             pend
);

    localparam logic [ADDR_W-1:0] ALIAS = ADDR_W'(pc_index(NUM_REGS));

    // Full-size view so any address indexes in range; the alias slot carries PC.
    logic [DATA_W-1:0] ents [NUM_REGS];
    logic [NUM_REGS-1:0] sbx;

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_ents
        assign ents[i] = store_flat[i*DATA_W +: DATA_W];
    end
    assign ents[NUM_REGS-1] = pc;

    assign sbx  = {1'b0, sb};
    assign pend = sbx[addr];

    // Bypass is held off during reset so the read cannot expose data that is being discarded.
    always_comb begin
        data = ents[addr];
        if (addr == ALIAS)
            data = pc;
        else if ((BYPASS != 0) && !rst && le0 && (rw0 == addr))
            data = pw0;
        else if ((BYPASS != 0) && !rst && le1 && (rw1 == addr))
            data = pw1;
    end

endmodule

// File: rtl/register_file_p.sv
// Operand-fetch register file: two write ports, three read ports, PC alias, RAW scoreboard.
module register_file_p
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LE0,
    input  logic [ADDR_W-1:0] RW0,
    input  logic [DATA_W-1:0] PW0,
    input  logic              LE1,
    input  logic [ADDR_W-1:0] RW1,
    input  logic [DATA_W-1:0] PW1,
    input  logic              SBS,
    input  logic [ADDR_W-1:0] RS,
    input  logic [DATA_W-1:0] PC,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic [DATA_W-1:0] PD,
    output logic              BA,
    output logic              BB,
    output logic              BD
);

    if (!valid_num_regs(NUM_REGS)) begin : g_bad_num_regs
        $error("register_file_p: NUM_REGS must be a power of two and at least 4");
    end

    logic [(NUM_REGS-1)*DATA_W-1:0] store_flat;
    logic [NUM_REGS-2:0]            sb;

    // Only indices 0..NUM_REGS-2 get flops, so alias writes and alias scoreboard sets fall away.
    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
        logic [DATA_W-1:0] q;
        logic              hit0, hit1;

        assign hit0 = LE0 && (RW0 == IDX);
        assign hit1 = LE1 && (RW1 == IDX);

        always_ff @(posedge Clk) begin
            if (Reset)
                q <= '0;
            else if (hit0)
                q <= PW0;
            else if (hit1)
                q <= PW1;
        end

        // A set in the same cycle as a clearing write wins: a new producer has just issued.
        always_ff @(posedge Clk) begin
            if (Reset)
                sb[i] <= 1'b0;
            else if (SBS && (RS == IDX))
                sb[i] <= 1'b1;
            else if (hit0 || hit1)
                sb[i] <= 1'b0;
        end

        assign store_flat[i*DATA_W +: DATA_W] = q;
    end

    rf_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_port_a (
        .rst(Reset), .addr(RA), .store_flat(store_flat), .sb(sb),
        .le0(LE0), .rw0(RW0), .pw0(PW0), .le1(LE1), .rw1(RW1), .pw1(PW1),
        .pc(PC), .data(PA), .pend(BA)
    );

    rf_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_port_b (
        .rst(Reset), .addr(RB), .store_flat(store_flat), .sb(sb),
        .le0(LE0), .rw0(RW0), .pw0(PW0), .le1(LE1), .rw1(RW1), .pw1(PW1),
        .pc(PC), .data(PB), .pend(BB)
    );

    rf_read_port #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_port_d (
        .rst(Reset), .addr(RD), .store_flat(store_flat), .sb(sb),
        .le0(LE0), .rw0(RW0), .pw0(PW0), .le1(LE1), .rw1(RW1), .pw1(PW1),
        .pc(PC), .data(PD), .pend(BD)
    );

endmodule

// File: tb/tb_register_file_p.sv
// Directed bench: one bypassing and one non-bypassing instance driven by the same stimulus.
module tb_register_file_p;

    logic        Clk = 1'b0;
    logic        Reset, LE0, LE1, SBS;
    logic [3:0]  RW0, RW1, RS, RA, RB, RD;
    logic [31:0] PW0, PW1, PC;

    logic [31:0] pa1, pb1, pd1, pa0, pb0, pd0;
    logic        ba1, bb1, bd1, ba0, bb0, bd0;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    register_file_p #(.DATA_W(32), .NUM_REGS(16), .BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .LE0(LE0), .RW0(RW0), .PW0(PW0), .LE1(LE1), .RW1(RW1), .PW1(PW1),
        .SBS(SBS), .RS(RS), .PC(PC), .RA(RA), .RB(RB), .RD(RD),
        .PA(pa1), .PB(pb1), .PD(pd1), .BA(ba1), .BB(bb1), .BD(bd1)
    );

    register_file_p #(.DATA_W(32), .NUM_REGS(16), .BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset(Reset),
        .LE0(LE0), .RW0(RW0), .PW0(PW0), .LE1(LE1), .RW1(RW1), .PW1(PW1),
        .SBS(SBS), .RS(RS), .PC(PC), .RA(RA), .RB(RB), .RD(RD),
        .PA(pa0), .PB(pb0), .PD(pd0), .BA(ba0), .BB(bb0), .BD(bd0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        LE0 = 0; LE1 = 0; SBS = 0; Reset = 0;
    endtask

    initial begin
        Reset = 1; LE0 = 0; LE1 = 0; SBS = 0;
        RW0 = 0; RW1 = 0; RS = 0; PW0 = 0; PW1 = 0;
        PC = 0; RA = 0; RB = 0; RD = 0;
        // Writes offered during reset must be discarded
        LE0 = 1; RW0 = 1; PW0 = 32'h1234_5678;
        tick();
        idle();

        RA = 0; RB = 7; RD = 15; PC = 32'h0000_0100;
        #1;
        check("rst_pa", pa1, 32'h0);
        check("rst_pb", pb1, 32'h0);
        check("rst_pd_alias", pd1, 32'h0000_0100);
        check("rst_flags", {29'd0, ba1, bb1, bd1}, 32'h0);
        RA = 1;
        #1;
        check("rst_write_dropped", pa1, 32'h0);

        // Same-cycle write and read of R3
        LE0 = 1; RW0 = 3; PW0 = 32'hDEAD_BEEF; RA = 3;
        #1;
        check("byp_pa_before", pa1, 32'hDEAD_BEEF);
        check("nobyp_pa_before", pa0, 32'h0);
        tick();
        idle();
        #1;
        check("byp_pa_after", pa1, 32'hDEAD_BEEF);
        check("nobyp_pa_after", pa0, 32'hDEAD_BEEF);

        // Both ports to R5: port 0 wins, in bypass and in storage
        LE0 = 1; LE1 = 1; RW0 = 5; RW1 = 5; PW0 = 32'h11; PW1 = 32'h22; RA = 5;
        #1;
        check("dual_bypass_prio", pa1, 32'h11);
        tick();
        idle();
        #1;
        check("dual_r5", pa1, 32'h11);
        check("dual_r5_nb", pa0, 32'h11);

        LE1 = 1; RW1 = 6; PW1 = 32'h33; RB = 6;
        #1;
        check("p1_bypass", pb1, 32'h33);
        check("p1_nobypass", pb0, 32'h0);
        tick();
        idle();
        #1;
        check("p1_r6", pb1, 32'h33);
        check("p1_r5_kept", pa1, 32'h11);

        // Write aimed at the PC alias
        LE0 = 1; RW0 = 15; PW0 = 32'hFFFF_FFFF; PC = 32'h40; RA = 15; RB = 3; RD = 5;
        #1;
        check("alias_before", pa1, 32'h40);
        check("alias_before_nb", pa0, 32'h40);
        tick();
        idle();
        #1;
        check("alias_after", pa1, 32'h40);
        check("alias_r3_kept", pb1, 32'hDEAD_BEEF);
        check("alias_r5_kept", pd1, 32'h11);
        RD = 6;
        PC = 32'h44;
        #1;
        check("alias_r6_kept", pd1, 32'h33);
        check("alias_tracks_pc", pa1, 32'h44);

        // Scoreboard: set, set-vs-clear collision, clear
        SBS = 1; RS = 4; RB = 4;
        #1;
        check("sb_no_forward", {31'd0, bb1}, 32'h0);
        tick();
        idle();
        #1;
        check("sb_set", {31'd0, bb1}, 32'h1);
        check("sb_set_nb", {31'd0, bb0}, 32'h1);

        LE0 = 1; RW0 = 4; PW0 = 32'hAA; SBS = 1; RS = 4;
        tick();
        idle();
        #1;
        check("sb_set_wins", {31'd0, bb1}, 32'h1);
        check("sb_collide_data", pb1, 32'hAA);

        LE0 = 1; RW0 = 4; PW0 = 32'hAB;
        tick();
        idle();
        #1;
        check("sb_clear_p0", {31'd0, bb1}, 32'h0);

        SBS = 1; RS = 7; RB = 7;
        tick();
        idle();
        LE1 = 1; RW1 = 7; PW1 = 32'h77;
        #1;
        check("sb_pend_r7", {31'd0, bb1}, 32'h1);
        tick();
        idle();
        #1;
        check("sb_clear_p1", {31'd0, bb1}, 32'h0);

        SBS = 1; RS = 15; RD = 15;
        tick();
        idle();
        #1;
        check("sb_alias_zero", {31'd0, bd1}, 32'h0);

        // Reset in the middle of operation
        LE0 = 1; RW0 = 2; PW0 = 32'h55; SBS = 1; RS = 2; RA = 2;
        tick();
        idle();
        #1;
        check("mid_r2", pa1, 32'h55);
        check("mid_b2", {31'd0, ba1}, 32'h1);

        Reset = 1; LE0 = 1; RW0 = 2; PW0 = 32'h99;
        #1;
        check("rst_no_bypass_pre", pa1, 32'h55);
        tick();
        #1;
        check("rst_no_bypass_post", pa1, 32'h0);
        idle();
        #1;
        check("rst_r2_clear", pa1, 32'h0);
        check("rst_b2_clear", {31'd0, ba1}, 32'h0);
        RB = 3; RD = 15; PC = 32'h200;
        #1;
        check("rst_r3_clear", pb1, 32'h0);
        check("rst_alias_pc", pd1, 32'h200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_p.md
Name: register_file_p

Overview:
Parametrised successor to the current 16x32 three-read/one-write register file, used in the datapath's operand-fetch stage. Features:
- Configurable data width and register count.
- Two write ports: port 0 for ALU/load result, port 1 for base-register writeback.
- Synchronous clear.
- Optional write-to-read bypass.
- Per-register pending (scoreboard) bits so the control unit can detect RAW hazards.

The highest-index register stays an alias of the externally supplied PC.

Parameters:
DATA_W, 32, register and port data width in bits
NUM_REGS, 16, number of architectural registers; power of two, minimum 4; index NUM_REGS-1 is the PC alias
ADDR_W, $clog2(NUM_REGS), register address width; derived, not to be overridden
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see the old value until after the edge

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
LE0  in  1  write enable, port 0 (high priority)
RW0  in  ADDR_W  write address, port 0
PW0  in  DATA_W  write data, port 0
LE1  in  1  write enable, port 1 (low priority)
RW1  in  ADDR_W  write address, port 1
PW1  in  DATA_W  write data, port 1
SBS  in  1  scoreboard set strobe
RS  in  ADDR_W  register to mark pending
PC  in  DATA_W  current PC value, returned for reads of index NUM_REGS-1
RA, RB, RD  in  ADDR_W  read addresses
PA, PB, PD  out  DATA_W  read data
BA, BB, BD  out  1  pending flag for RA/RB/RD

Behaviour:
- Storage: registers 0..NUM_REGS-2, DATA_W flops each. There is no storage for index NUM_REGS-1.
- Reset:
  - On a rising Clk with Reset=1, all storage and all scoreboard bits clear to 0.
  - Reset dominates LE0, LE1 and SBS in that cycle; writes presented during the reset cycle are discarded.
  - After reset, PA/PB/PD read 0 for every stored index and PC for the alias; BA/BB/BD read 0.
- Writes:
  - On a rising Clk, LEx=1 writes PWx into RWx; latency is one edge.
  - LE0 and LE1 to the same address in one cycle: port 0 data is stored and port 1 is dropped.
  - Writes to index NUM_REGS-1 are ignored; PC is owned by the fetch unit.
- Reads:
  - Combinational.
  - Index NUM_REGS-1 returns PC directly, with no bypass.
  - BYPASS=1: if LE0=1 and RW0 matches the read address, return PW0. Else if LE1=1 and RW1 matches, return PW1. Else return stored value.
  - BYPASS=1 with Reset=1: bypass is suppressed and the stored value is returned.
  - BYPASS=0: always return the stored value.
- Scoreboard:
  - One bit per stored register.
  - On a rising Clk, SBS=1 sets bit RS.
  - LEx=1 clears bit RWx.
  - Set and clear of the same bit in one cycle: set wins, because a new producer has issued.
  - SBS to the alias index is ignored.
  - BA/BB/BD reflect registered bits only, with no same-cycle forwarding. Alias index always reads 0.
- All read ports are independent; any two or all three ports may address the same register.

Decomposition:
- Package rf_pkg:
  - default DATA_W and NUM_REGS constants
  - localparam/function giving the PC alias index (NUM_REGS-1)
  - elaboration-time check that NUM_REGS is a power of two and at least 4
- Sub-module rf_read_port, instantiated three times:
  - inputs: address, storage array, scoreboard vector, both write ports, PC
  - outputs: data and pending flag
  - contains the alias select, the bypass priority chain and the stored-value mux
- Storage, write-priority logic and scoreboard update stay in the top level.

Test Plan:
- Reset, then set RA=0, RB=7, RD=15 with PC=0x0000_0100. Required: PA=0, PB=0, PD=0x0000_0100, and BA=BB=BD=0.
- Write R3 with LE0=1, RW0=3, PW0=0xDEAD_BEEF, while RA=3 in the same cycle. Required with BYPASS=1: PA=0xDEAD_BEEF before the edge. Required with BYPASS=0: PA=0 before the edge and 0xDEAD_BEEF after it.
- Dual write to the same register: LE0=LE1=1, RW0=RW1=5, PW0=0x11, PW1=0x22. Required: R5=0x11 after the edge. Then LE1 only, RW1=6, PW1=0x33. Required: R6=0x33, R5 unchanged.
- Write to the alias: LE0=1, RW0=15, PW0=0xFFFF_FFFF, PC=0x40. Required: RA=15 reads 0x40 both before and after the edge, and no stored register changes.
- Scoreboard:
  - SBS=1, RS=4; after the edge, RB=4 gives BB=1.
  - Next cycle LE0=1, RW0=4 together with SBS=1, RS=4. Required: BB stays 1 (set wins).
  - Next cycle LE0=1, RW0=4 alone. Required: BB=0 after the edge.
- Reset mid-operation: R2=0x55 and bit 2 pending. Assert Reset together with LE0=1, RW0=2, PW0=0x99. Required: R2=0, bit 2 clear, and PA(RA=2)=0 during the reset cycle (no bypass).
